// File: rtl/ram_pkg.sv
// ram_pkg: shared widths and requester ids for the display/time RAM arbiter
package ram_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {REQ_NONE, REQ_DISP, REQ_RTC, REQ_EDIT} req_id_e;
endpackage

// File: rtl/ram_arb_if.sv
// ram_arb_if: requester handshakes and RAM macro signals around the arbiter
interface ram_arb_if;
    import ram_pkg::*;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic [DATA_W-1:0] disp_rdata;
    logic              disp_rvalid;
    logic              rtc_req;
    logic              rtc_we;
    logic [ADDR_W-1:0] rtc_addr;
    logic [DATA_W-1:0] rtc_wdata;
    logic              rtc_gnt;
    logic [DATA_W-1:0] rtc_rdata;
    logic              rtc_rvalid;
    logic              edit_req;
    logic              edit_we;
    logic [ADDR_W-1:0] edit_addr;
    logic [DATA_W-1:0] edit_wdata;
    logic              edit_gnt;
    logic [DATA_W-1:0] edit_rdata;
    logic              edit_rvalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_w;
    logic [DATA_W-1:0] ram_r;
    logic [15:0]       disp_stall;
    modport slave (
        input  disp_req, disp_addr, rtc_req, rtc_we, rtc_addr, rtc_wdata,
               edit_req, edit_we, edit_addr, edit_wdata, ram_r,
        output disp_gnt, disp_rdata, disp_rvalid, rtc_gnt, rtc_rdata, rtc_rvalid,
               edit_gnt, edit_rdata, edit_rvalid, ram_addr, ram_we, ram_w, disp_stall
    );
    modport master (
        output disp_req, disp_addr, rtc_req, rtc_we, rtc_addr, rtc_wdata,
               edit_req, edit_we, edit_addr, edit_wdata, ram_r,
        input  disp_gnt, disp_rdata, disp_rvalid, rtc_gnt, rtc_rdata, rtc_rvalid,
               edit_gnt, edit_rdata, edit_rvalid, ram_addr, ram_we, ram_w, disp_stall
    );
endinterface

// File: rtl/ram_arb_age.sv
// arb_age: saturating wait counter that promotes a requester starved by the scanner
module arb_age #(
    parameter int STARVE_MAX = 7,
    parameter int AGE_W      = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic promoted
);
    logic [AGE_W-1:0] age_q, age_d;
    assign promoted = age_q == AGE_W'(STARVE_MAX);
    always_comb age_d = (!req || gnt) ? '0 : promoted ? age_q : age_q + 1'b1;
    always_ff @(posedge clk) age_q <= rst ? '0 : age_d;
endmodule

// File: rtl/ram_arb.sv
// ram_arb: single-port RAM arbiter, disp > rtc > edit with starvation promotion
module ram_arb import ram_pkg::*; #(
    parameter int STARVE_MAX = 7,
    parameter int AGE_W      = 3
) (
    input logic      clk,
    input logic      rst,
    ram_arb_if.slave bus
);
    req_id_e           sel, own_q, own_d;
    logic              rtc_prom, edit_prom, sel_we;
    logic [ADDR_W-1:0] sel_addr, addr_q, addr_d;
    logic [DATA_W-1:0] sel_wdata, w_q, w_d;
    logic [DATA_W-1:0] disp_hold_q, disp_hold_d, rtc_hold_q, rtc_hold_d, edit_hold_q, edit_hold_d;
    logic [15:0]       stall_q, stall_d;

    arb_age #(.STARVE_MAX(STARVE_MAX), .AGE_W(AGE_W)) u_rtc_age (
        .clk(clk), .rst(rst), .req(bus.rtc_req), .gnt(bus.rtc_gnt), .promoted(rtc_prom));
    arb_age #(.STARVE_MAX(STARVE_MAX), .AGE_W(AGE_W)) u_edit_age (
        .clk(clk), .rst(rst), .req(bus.edit_req), .gnt(bus.edit_gnt), .promoted(edit_prom));

    always_comb begin
        sel = rst ? REQ_NONE
            : (bus.rtc_req && rtc_prom) ? REQ_RTC
            : (bus.edit_req && edit_prom) ? REQ_EDIT
            : bus.disp_req ? REQ_DISP
            : bus.rtc_req ? REQ_RTC
            : bus.edit_req ? REQ_EDIT : REQ_NONE;
        sel_addr = sel == REQ_DISP ? bus.disp_addr : sel == REQ_RTC ? bus.rtc_addr : bus.edit_addr;
        sel_we = (sel == REQ_RTC && bus.rtc_we) || (sel == REQ_EDIT && bus.edit_we);
        sel_wdata = sel == REQ_RTC ? bus.rtc_wdata : bus.edit_wdata;
        addr_d = sel != REQ_NONE ? sel_addr : addr_q;
        w_d = sel_we ? sel_wdata : w_q;
        own_d = (sel != REQ_NONE && !sel_we) ? sel : REQ_NONE;
        // read data passes straight through on the valid cycle and is captured for later
        disp_hold_d = own_q == REQ_DISP ? bus.ram_r : disp_hold_q;
        rtc_hold_d = own_q == REQ_RTC ? bus.ram_r : rtc_hold_q;
        edit_hold_d = own_q == REQ_EDIT ? bus.ram_r : edit_hold_q;
        stall_d = (bus.disp_req && sel != REQ_DISP && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    assign bus.disp_gnt    = sel == REQ_DISP;
    assign bus.rtc_gnt     = sel == REQ_RTC;
    assign bus.edit_gnt    = sel == REQ_EDIT;
    assign bus.ram_addr    = addr_d;
    assign bus.ram_we      = sel_we;
    assign bus.ram_w       = w_d;
    assign bus.disp_rvalid = own_q == REQ_DISP;
    assign bus.rtc_rvalid  = own_q == REQ_RTC;
    assign bus.edit_rvalid = own_q == REQ_EDIT;
    assign bus.disp_rdata  = disp_hold_d;
    assign bus.rtc_rdata   = rtc_hold_d;
    assign bus.edit_rdata  = edit_hold_d;
    assign bus.disp_stall  = stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            own_q       <= REQ_NONE;
            addr_q      <= '0;
            w_q         <= '0;
            disp_hold_q <= '0;
            rtc_hold_q  <= '0;
            edit_hold_q <= '0;
            stall_q     <= '0;
        end else begin
            own_q       <= own_d;
            addr_q      <= addr_d;
            w_q         <= w_d;
            disp_hold_q <= disp_hold_d;
            rtc_hold_q  <= rtc_hold_d;
            edit_hold_q <= edit_hold_d;
            stall_q     <= stall_d;
        end
    end
endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed and randomized checks of ram_arb against a cycle-level behavioural model
module tb_ram_arb;
    import ram_pkg::*;
    localparam int SM = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ram_arb_if bus();
    ram_arb #(.STARVE_MAX(SM), .AGE_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0] mem [16] = '{8'h00, 8'h11, 8'h22, 8'h59, 8'h44, 8'h27, 8'h31, 8'h77,
                             8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    logic [7:0] ref_mem [16] = '{8'h00, 8'h11, 8'h22, 8'h59, 8'h44, 8'h27, 8'h31, 8'h77,
                                 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_w;
        bus.ram_r <= mem[bus.ram_addr];
    end

    int n_run = 0;
    int n_fail = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: consecutive-wait counts, pending read, per-port holds, last address/data, stall count
    bit         chk_en = 1'b1;
    int         m_wr = 0, m_we = 0, m_stall = 0;
    req_id_e    m_pend = REQ_NONE, m_g = REQ_NONE, g;
    logic [7:0] m_pdata = 8'h00, m_w = 8'h00, wd;
    logic [7:0] m_hold [4] = '{default: 8'h00};
    logic [3:0] m_addr = 4'h0, a;
    logic       wo;

    always @(negedge clk) if (chk_en) begin
        if (rst) g = REQ_NONE;
        else if (bus.rtc_req && m_wr >= SM) g = REQ_RTC;
        else if (bus.edit_req && m_we >= SM) g = REQ_EDIT;
        else if (bus.disp_req) g = REQ_DISP;
        else if (bus.rtc_req) g = REQ_RTC;
        else if (bus.edit_req) g = REQ_EDIT;
        else g = REQ_NONE;
        a  = g == REQ_DISP ? bus.disp_addr : g == REQ_RTC ? bus.rtc_addr : bus.edit_addr;
        wo = (g == REQ_RTC && bus.rtc_we) || (g == REQ_EDIT && bus.edit_we);
        wd = g == REQ_RTC ? bus.rtc_wdata : bus.edit_wdata;
        check("gnt", 32'({bus.disp_gnt, bus.rtc_gnt, bus.edit_gnt}),
              32'({g == REQ_DISP, g == REQ_RTC, g == REQ_EDIT}));
        check("ram_we", 32'(bus.ram_we), 32'(wo));
        check("ram_addr", 32'(bus.ram_addr), 32'(g != REQ_NONE ? a : m_addr));
        check("ram_w", 32'(bus.ram_w), 32'(wo ? wd : m_w));
        check("rvalid", 32'({bus.disp_rvalid, bus.rtc_rvalid, bus.edit_rvalid}),
              32'({m_pend == REQ_DISP, m_pend == REQ_RTC, m_pend == REQ_EDIT}));
        check("disp_rdata", 32'(bus.disp_rdata), 32'(m_pend == REQ_DISP ? m_pdata : m_hold[1]));
        check("rtc_rdata", 32'(bus.rtc_rdata), 32'(m_pend == REQ_RTC ? m_pdata : m_hold[2]));
        check("edit_rdata", 32'(bus.edit_rdata), 32'(m_pend == REQ_EDIT ? m_pdata : m_hold[3]));
        check("disp_stall", 32'(bus.disp_stall), 32'(m_stall));
        if (rst) begin
            m_wr = 0; m_we = 0; m_stall = 0; m_pend = REQ_NONE;
            m_hold = '{default: 8'h00}; m_addr = 4'h0; m_w = 8'h00;
        end else begin
            if (m_pend != REQ_NONE) m_hold[int'(m_pend)] = m_pdata;
            m_pend = (g != REQ_NONE && !wo) ? g : REQ_NONE;
            m_pdata = ref_mem[a];
            if (wo) begin ref_mem[a] = wd; m_w = wd; end
            if (g != REQ_NONE) m_addr = a;
            m_wr = (bus.rtc_req && g != REQ_RTC) ? m_wr + 1 : 0;
            m_we = (bus.edit_req && g != REQ_EDIT) ? m_we + 1 : 0;
            if (bus.disp_req && g != REQ_DISP && m_stall < 65535) m_stall++;
        end
        m_g = g;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_req = 1'b0; bus.rtc_req = 1'b0; bus.rtc_we = 1'b0;
        bus.edit_req = 1'b0; bus.edit_we = 1'b0;
    endtask

    initial begin
        int wr, we, mr, me, ne;
        bus.disp_req = 1'b1; bus.disp_addr = 4'h0;
        bus.rtc_req = 1'b1; bus.rtc_we = 1'b0; bus.rtc_addr = 4'h0; bus.rtc_wdata = 8'h00;
        bus.edit_req = 1'b1; bus.edit_we = 1'b0; bus.edit_addr = 4'h0; bus.edit_wdata = 8'h00;
        repeat (3) tick();
        #3 check("t1_rst_gnt", 32'({bus.disp_gnt, bus.rtc_gnt, bus.edit_gnt}), 32'(0));
        check("t1_rst_rvalid", 32'({bus.disp_rvalid, bus.rtc_rvalid, bus.edit_rvalid}), 32'(0));
        check("t1_rst_we", 32'(bus.ram_we), 32'(0));
        tick(); rst = 1'b0;
        #3 check("t1_first_disp_gnt", 32'(bus.disp_gnt), 32'(1));
        tick(); idle();
        repeat (2) tick();

        bus.disp_req = 1'b1; bus.disp_addr = 4'h3;
        #3 check("t2_gnt", 32'(bus.disp_gnt), 32'(1));
        tick(); bus.disp_req = 1'b0;
        #3 check("t2_rvalid", 32'(bus.disp_rvalid), 32'(1));
        check("t2_rdata", 32'(bus.disp_rdata), 32'h59);
        tick();
        #3 check("t2_rvalid_after", 32'(bus.disp_rvalid), 32'(0));
        check("t2_rdata_held", 32'(bus.disp_rdata), 32'h59);

        tick();
        bus.disp_req = 1'b1; bus.disp_addr = 4'h1;
        bus.rtc_req = 1'b1; bus.rtc_we = 1'b1; bus.rtc_addr = 4'h0; bus.rtc_wdata = 8'h12;
        for (int i = 0; i < 8; i++) begin
            #3 check("t3_rtc_gnt", 32'(bus.rtc_gnt), 32'(i == 7));
            if (i == 7) begin
                check("t3_ram_we", 32'(bus.ram_we), 32'(1));
                check("t3_ram_w", 32'(bus.ram_w), 32'h12);
                check("t3_ram_addr", 32'(bus.ram_addr), 32'h0);
            end
            tick();
        end
        bus.rtc_req = 1'b0; bus.rtc_we = 1'b0;
        #3 check("t3_stall", 32'(bus.disp_stall), 32'(1));
        tick(); idle();
        repeat (2) tick();

        bus.disp_req = 1'b1; bus.disp_addr = 4'h1;
        bus.rtc_req = 1'b1; bus.rtc_addr = 4'h2;
        bus.edit_req = 1'b1; bus.edit_addr = 4'h7;
        wr = 0; we = 0; mr = 0; me = 0; ne = 0;
        for (int i = 0; i < 48; i++) begin
            #3;
            if (bus.rtc_gnt) wr = 0; else begin wr++; if (wr > mr) mr = wr; end
            if (bus.edit_gnt) we = 0; else begin we++; if (we > me) me = we; end
            if (bus.edit_gnt) ne++;
            if (i == 9) begin
                check("t4_edit_rvalid", 32'({bus.disp_rvalid, bus.rtc_rvalid, bus.edit_rvalid}), 32'(1));
                check("t4_edit_rdata", 32'(bus.edit_rdata), 32'h77);
            end
            tick();
        end
        check("t4_rtc_maxwait", 32'(mr), 32'(SM));
        check("t4_edit_maxwait", 32'(me), 32'(SM + 1));
        check("t4_edit_grants", 32'(ne), 32'(5));
        idle();
        repeat (3) tick();

        bus.edit_req = 1'b1; bus.edit_addr = 4'h5;
        #3 check("t5_edit_gnt", 32'(bus.edit_gnt), 32'(1));
        tick(); bus.edit_req = 1'b0; bus.disp_req = 1'b1; bus.disp_addr = 4'h6;
        #3 check("t5_disp_gnt", 32'(bus.disp_gnt), 32'(1));
        check("t5_edit_rvalid", 32'(bus.edit_rvalid), 32'(1));
        check("t5_edit_rdata", 32'(bus.edit_rdata), 32'h27);
        tick(); bus.disp_req = 1'b0;
        #3 check("t5_disp_rvalid", 32'({bus.disp_rvalid, bus.edit_rvalid}), 32'b10);
        check("t5_disp_rdata", 32'(bus.disp_rdata), 32'h31);

        repeat (3000) begin
            tick();
            rst = $urandom_range(0, 299) == 0;
            if (!bus.disp_req || m_g == REQ_DISP) begin
                bus.disp_req = $urandom_range(0, 3) != 0; bus.disp_addr = 4'($urandom);
            end
            if (!bus.rtc_req || m_g == REQ_RTC) begin
                bus.rtc_req = $urandom_range(0, 2) == 0; bus.rtc_we = 1'($urandom);
                bus.rtc_addr = 4'($urandom); bus.rtc_wdata = 8'($urandom);
            end
            if (!bus.edit_req || m_g == REQ_EDIT) begin
                bus.edit_req = $urandom_range(0, 2) == 0; bus.edit_we = 1'($urandom);
                bus.edit_addr = 4'($urandom); bus.edit_wdata = 8'($urandom);
            end
        end

        tick();
        rst = 1'b0; chk_en = 1'b0; idle();
        force dut.rtc_prom = 1'b1;
        bus.disp_req = 1'b1; bus.rtc_req = 1'b1;
        repeat (70000) tick();
        #3 check("t6_stall_sat", 32'(bus.disp_stall), 32'hFFFF);
        check("t6_disp_blocked", 32'(bus.disp_gnt), 32'(0));
        tick();
        #3 check("t6_stall_nowrap", 32'(bus.disp_stall), 32'hFFFF);
        release dut.rtc_prom;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
